// File: rtl/seq_mod_div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default
// width and the magnitude / sign-restore helpers used around the datapath.
package seq_mod_div_pkg;

  localparam int WIDTH_DEF = 8;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  // Conditional two's-complement negate. Callers zero-extend a WIDTH-bit
  // value and keep the low WIDTH bits, which equals a WIDTH-bit negate.
  function automatic logic [31:0] mag_of(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Re-apply a sign to an unsigned magnitude (same operation as mag_of).
  function automatic logic [31:0] sign_restore(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/seq_mod_div_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder and subtract the divisor magnitude when it fits.
module seq_mod_div_step
  import seq_mod_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0] shifted;

  // Trial subtract; rem[WIDTH] is always 0 in a restoring divider but is
  // folded in so a set top bit still forces a subtract.
  always_comb begin
    shifted = {rem[WIDTH-1:0], bit_in};
    qbit    = rem[WIDTH] | (shifted >= {1'b0, dvs});
    rem_nxt = qbit ? (shifted - {1'b0, dvs}) : shifted;
  end

endmodule

// File: rtl/seq_mod_div.sv
// Sequential signed/unsigned divider, one quotient bit per cycle.
// Operands are converted to magnitudes at accept, divided MSB first, and the
// signs restored when the final result is registered on entry to FINISH.
module seq_mod_div
  import seq_mod_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int          CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [WIDTH:0] prem;
  logic [WIDTH-1:0] dq;    // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;   // divisor magnitude
  logic           neg_q, neg_r;

  logic           a_neg, b_neg;
  logic [WIDTH:0] rem_nxt;
  logic           qbit;

  // Operand signs only matter in signed mode
  always_comb begin
    a_neg = signed_mode & dividend[WIDTH-1];
    b_neg = signed_mode & divisor[WIDTH-1];
  end

  seq_mod_div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (prem),
    .bit_in  (dq[WIDTH-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // Control FSM, datapath registers and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      prem        <= '0;
      dq          <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            prem  <= '0;
            dq    <= WIDTH'(mag_of(32'(dividend), a_neg));
            dvs   <= WIDTH'(mag_of(32'(divisor), b_neg));
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (divisor == '0) begin
              state       <= ST_FINISH;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= ST_RUN;
              div_by_zero <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          prem <= rem_nxt;
          dq   <= {dq[WIDTH-2:0], qbit};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            // last step's result goes straight to the outputs, sign restored
            state     <= ST_FINISH;
            done      <= 1'b1;
            quotient  <= WIDTH'(sign_restore(32'({dq[WIDTH-2:0], qbit}), neg_q));
            remainder <= WIDTH'(sign_restore(32'(rem_nxt[WIDTH-1:0]), neg_r));
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_mod_div.md
SEQ_MOD_DIV -- requirements
Module: seq_mod_div

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request pulse; sampled only in IDLE.
REQ-005 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched with start.
REQ-006 dividend  in  WIDTH  numerator; latched with start.
REQ-007 divisor  in  WIDTH  denominator; latched with start.
REQ-008 busy  out  1  high from accepting edge until done cycle inclusive.
REQ-009 done  out  1  one-cycle pulse; results valid.
REQ-010 quotient  out  WIDTH  result quotient.
REQ-011 remainder  out  WIDTH  result remainder (modulo).
REQ-012 div_by_zero  out  1  set when latched divisor was zero.

Function
REQ-013 FSM states IDLE, RUN, FINISH; IDLE->RUN on start with nonzero divisor; IDLE->FINISH on start with zero divisor; RUN->FINISH after WIDTH RUN cycles; FINISH->IDLE unconditionally.
REQ-014 start while busy SHALL be ignored; operands, mode and results unaffected.
REQ-015 RUN performs restoring shift-subtract, one quotient bit per cycle, MSB first, on operand magnitudes; internal partial remainder WIDTH+1 bits.
REQ-016 Latency: done SHALL assert exactly WIDTH+1 cycles after the accepting edge (nonzero divisor), exactly 1 cycle after (zero divisor).
REQ-017 Unsigned mode: quotient = floor(dividend/divisor), remainder = dividend mod divisor.
REQ-018 Signed mode: quotient truncated toward zero; remainder takes dividend's sign; |remainder| < |divisor|.
REQ-019 Signed most-negative / -1: quotient = most-negative value (wrap), remainder = 0, no flag.
REQ-020 Zero divisor: quotient = all ones, remainder = latched dividend, div_by_zero = 1.
REQ-021 quotient, remainder, div_by_zero SHALL update only in FINISH and hold until the next FINISH.
REQ-022 div_by_zero SHALL clear at the next accepted start.
REQ-023 start in the FINISH cycle is ignored; start in the following IDLE cycle is accepted (back-to-back throughput WIDTH+2 cycles).
REQ-024 Intermediate datapath values SHALL never appear on quotient/remainder outputs.

Reset
REQ-025 rst asserted SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, bit counter=0.
REQ-026 rst mid-RUN SHALL abort the operation with no done pulse; first start after rst release is accepted normally.

Structure
REQ-027 Shared package seq_mod_div_pkg SHALL hold the FSM state enum, WIDTH default, and helper functions for magnitude and sign restore.
REQ-028 One sub-module, seq_mod_div_step: combinational single shift-subtract step (partial remainder, next dividend bit, divisor magnitude -> new partial remainder, quotient bit).
REQ-029 Bit counter width SHALL be clog2(WIDTH+1).

Verification
REQ-030 WIDTH=8, unsigned 200/7 -> quotient 28, remainder 4, done 9 cycles after accept.
REQ-031 WIDTH=8, unsigned 55/0 -> quotient 255, remainder 55, div_by_zero 1, done 1 cycle after accept.
REQ-032 WIDTH=8, signed -7/2 -> quotient -3 (0xFD), remainder -1 (0xFF); signed 7/-2 -> quotient -3, remainder 1.
REQ-033 WIDTH=8, signed -128/-1 -> quotient 0x80, remainder 0, div_by_zero 0.
REQ-034 start with 100/3 then start with 9/9 two cycles later -> second ignored; result 33 r 1; 9/9 in the cycle after FINISH -> accepted, 1 r 0.
REQ-035 rst pulse 4 cycles into 250/6 -> no done, all outputs 0 immediately; following 250/6 -> 41 r 4.
